// File: rtl/ibex_pkg.sv
// Shared Ibex bus types used by the simulation bus responder.
package ibex_pkg;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } ibex_bus_rsp_t;

endpackage

// File: rtl/ibex_bus_rsp_fifo.sv
// In-order response queue for ibex_bus_responder; a pop and a push may occur in the same cycle.
module ibex_bus_rsp_fifo
   import ibex_pkg::*;
#(
   parameter int unsigned Depth = 2,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  ibex_bus_rsp_t   data_i,
   input  logic            pop_i,
   output ibex_bus_rsp_t   data_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   ibex_bus_rsp_t   entries_q [Depth];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] count_q, count_d;

   // Explicit wrap so non-power-of-two depths stay in range.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(Depth - 1)) begin
         return '0;
      end
      return p + PtrW'(1);
   endfunction

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) begin
         wptr_d = ptr_inc(wptr_q);
      end
      if (pop_i) begin
         rptr_d = ptr_inc(rptr_q);
      end
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         entries_q[wptr_q] <= data_i;
      end
   end

   assign data_o  = entries_q[rptr_q];
   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

   assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CntW'(Depth));
   assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> !empty_o);

endmodule

// File: rtl/ibex_bus_responder.sv
// Memory-side Ibex bus responder: word-addressed SRAM, grant stalls, forced-error window,
// and in-order responses with bench-controlled back-pressure.
module ibex_bus_responder
   import ibex_pkg::*;
#(
   parameter int unsigned MemWords       = 1024,
   parameter logic [31:0] MemBase        = 32'h0000_0000,
   parameter int unsigned MaxOutstanding = 2,
   parameter logic [31:0] ErrBase        = 32'hFFFF_F000,
   parameter logic [31:0] ErrLimit       = 32'hFFFF_FFFF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   input  logic        stall_i,
   input  logic        rsp_hold_i
);

   localparam int unsigned IdxW    = $clog2(MemWords);
   localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
   localparam logic [31:0] MemSpan = (32'(MemWords) << 2) - 32'd1;
   localparam logic [31:0] ErrSpan = ErrLimit - ErrBase;

   logic [31:0]     mem_q [MemWords];

   logic [31:0]     addr_w;
   logic [31:0]     mem_off;
   logic [IdxW-1:0] mem_idx;
   logic            acc_err;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CntW-1:0] fifo_count;
   ibex_bus_rsp_t   rsp_push;
   ibex_bus_rsp_t   rsp_head;

   // Offset compares wrap below each base, so one unsigned test covers both bounds.
   always_comb begin
      addr_w  = addr_i & ~32'h3;
      mem_off = addr_w - MemBase;
      mem_idx = mem_off[IdxW+1:2];
      acc_err = ((addr_w - ErrBase) <= ErrSpan) || (mem_off > MemSpan);
   end

   always_comb begin
      rsp_push = '0;
      if (acc_err) begin
         rsp_push.err = 1'b1;
      end else if (!we_i) begin
         rsp_push.rdata = mem_q[mem_idx];
      end
   end

   assign pop      = !fifo_empty && !rsp_hold_i;
   assign rvalid_o = pop;
   assign gnt_o    = rst_ni && req_i && !stall_i && (!fifo_full || pop);
   assign rdata_o  = rvalid_o ? rsp_head.rdata : '0;
   assign err_o    = rvalid_o ? rsp_head.err   : 1'b0;

   always_ff @(posedge clk_i) begin
      if (gnt_o && we_i && !acc_err) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (be_i[k]) begin
               mem_q[mem_idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   ibex_bus_rsp_fifo #(
      .Depth(MaxOutstanding)
   ) u_rsp_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (gnt_o),
      .data_i (rsp_push),
      .pop_i  (pop),
      .data_o (rsp_head),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .count_o(fifo_count)
   );

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      fifo_count <= CntW'(MaxOutstanding));
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_i && !gnt_o) |=> ($stable(we_i) && $stable(be_i) &&
                             $stable(addr_i) && $stable(wdata_i)));

endmodule

// File: doc/ibex_bus_responder.md
Name: ibex_bus_responder

Overview:
Memory-side responder for the Ibex instruction/data bus protocol (req/gnt/rvalid, in-order responses, err). It sits on the far side of instr_*/data_* from the core and backs the bus with a word-addressed SRAM model. It is the standard slave for core-level simulation and formal harnesses. Grant stalls, response back-pressure and error ranges are exposed so benches can exercise the core's LSU and prefetch paths.

Parameters:
MemWords, 1024, SRAM depth in 32-bit words (power of two, >=4)
MemBase, 32'h0000_0000, byte address of word 0 (MemWords*4 aligned)
MaxOutstanding, 2, granted-but-unanswered requests held (1..8)
ErrBase, 32'hFFFF_F000, first byte address of forced-error window
ErrLimit, 32'hFFFF_FFFF, last byte address of forced-error window (inclusive)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async reset, active low
req_i  in  1  request valid from core
gnt_o  out  1  request accepted this cycle (combinational)
we_i  in  1  1=write, 0=read
be_i  in  4  byte enables
addr_i  in  32  byte address, bits [1:0] ignored
wdata_i  in  32  write data
rvalid_o  out  1  response valid
rdata_o  out  32  read data, valid with rvalid_o
err_o  out  1  bus error, valid with rvalid_o
stall_i  in  1  bench hook: suppress gnt_o
rsp_hold_i  in  1  bench hook: suppress rvalid_o

Behaviour:
- One clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: rvalid_o=0, rdata_o=0, err_o=0, response queue empty, count=0. gnt_o is combinational and evaluates to 0 under reset. SRAM contents are not reset.
- Queue: FIFO with MaxOutstanding entries of {rdata, err}, plus a count of width $clog2(MaxOutstanding+1).
- pop = rvalid_o. rvalid_o = !empty & !rsp_hold_i.
- gnt_o = req_i & !stall_i & (count < MaxOutstanding | pop). A pop frees its slot in the same cycle.
- On grant, address classification:
  - err = addr in [ErrBase, ErrLimit], or addr outside [MemBase, MemBase+4*MemWords-1]. The error window takes priority.
  - index = (addr - MemBase) >> 2, truncated to $clog2(MemWords) bits.
- On grant with a write and !err: update only the bytes with be_i[k]=1, at the clock edge. The queued entry is {32'h0, 0}.
- On grant with a read and !err: the queued entry is {mem[index], 0}. SRAM is read at grant time, so the read sees all earlier granted writes and no later ones.
- On grant with err: no SRAM access, no write. The queued entry is {32'h0, 1}.
- be_i=4'b0000 on a write is legal: no bytes change, normal response.
- Latency: the minimum is 1 cycle, meaning the grant at edge N gives rvalid_o high in cycle N+1. Responses are strictly in grant order.
- rdata_o/err_o show the head entry when rvalid_o=1 and are 0 otherwise.
- Simultaneous push and pop: count is unchanged. Full plus pop: a grant is allowed. Empty: rvalid_o=0 regardless of rsp_hold_i.
- Read and write pointers wrap modulo MaxOutstanding. Non-power-of-two depths use an explicit compare-and-clear.
- Requests without a grant are not latched; the core holds req_i and its fields until gnt_o.
- Reset mid-operation: all queued responses are discarded and none are emitted after reset. Writes already granted remain in the SRAM.
- Assertions (sim only):
  - count <= MaxOutstanding.
  - No pop when empty.
  - While req_i & !gnt_o, the request fields are stable in the next cycle.

Decomposition:
- Shared ibex_pkg gains typedef ibex_bus_rsp_t: packed struct {logic [31:0] rdata; logic err;}.
- Sub-module ibex_bus_rsp_fifo (parameter Depth, ibex_bus_rsp_t entries, push/pop/full/empty/count ports) owns the queue.
- The top level holds the SRAM array, address decode and grant logic.

Test Plan:
- Write 32'hDEADBEEF be=4'hF at 0x10, then read 0x10 -> rvalid_o one cycle after each grant; read returns 32'hDEADBEEF, err_o=0.
- Write 32'h11223344 be=4'b0101 over 32'hAABBCCDD at 0x20, read back -> 32'hAA22CC44.
- rsp_hold_i=1, MaxOutstanding=2, three back-to-back reads -> first two granted, third gnt_o=0; on rsp_hold_i release, the third is granted in the same cycle as the first rvalid_o; responses arrive in order.
- Read 0xFFFF_F004 and read MemBase+4*MemWords -> err_o=1, rdata_o=0. Write to 0xFFFF_F004 leaves every SRAM word unchanged.
- stall_i=1 with req_i=1 for 5 cycles -> gnt_o=0 throughout and no rvalid_o; on stall_i=0, grant in that cycle and rvalid_o in the next.
- Two reads granted with rsp_hold_i=1, then rst_ni pulsed low -> rvalid_o=0 immediately (asynchronously) and no stale responses after reset release.
